// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice: ALU control op encodings,
//   default widths and the arbiter FSM state type.
//   No ports (package).
//   Optional feature macro used by the slice: ALU_ARB_ILLEGAL_OP_EN.
package alu_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  typedef enum logic [3:0] {
    OP_ADD     = 4'b0000,
    OP_AND     = 4'b0001,
    OP_OR      = 4'b0010,
    OP_XOR     = 4'b0011,
    OP_SUB     = 4'b0100,
    OP_SLT     = 4'b0101,
    OP_SLTU    = 4'b0110,
    OP_SLL     = 4'b1000,
    OP_SRL     = 4'b1001,
    OP_SRA     = 4'b1010,
    OP_INVALID = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between the two requesters (issue side) and the
//   ALU arbiter. Signal suffixes are from the arbiter's point of view.
//   req_valid_i/req_ready_o : per-requester handshake (2 bits)
//   req_op_i/a_i/b_i        : per-requester payload, requester k in slice k
//   req_negzero_i           : per-requester branch-sense invert
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_id_o/result_o/taken_o : response payload
//   rsp_err_o               : only with ALU_ARB_ILLEGAL_OP_EN defined
//   modports: slave (arbiter), master (requesters + response consumer)
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [2*OP_W-1:0]   req_op_i;
  logic [2*DATA_W-1:0] req_a_i;
  logic [2*DATA_W-1:0] req_b_i;
  logic [1:0]          req_negzero_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic                rsp_id_o;
  logic [DATA_W-1:0]   rsp_result_o;
  logic                rsp_taken_o;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                rsp_err_o;
`endif

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_negzero_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_taken_o
`ifdef ALU_ARB_ILLEGAL_OP_EN
    , output rsp_err_o
`endif
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_negzero_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_taken_o
`ifdef ALU_ARB_ILLEGAL_OP_EN
    , input rsp_err_o
`endif
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin picker. A lone valid requester wins; when both are
//   valid the one that did not win last time is picked.
//   valid_i[1:0]  in   request valids
//   last_grant_i  in   index of the most recent winner
//   grant_o[1:0]  out  one-hot grant, zero when nothing is valid
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between requester 0 (integer execute) and
//   requester 1 (branch/address unit). Round-robin grant, operand capture,
//   one EXEC cycle driving the ALU, registered response with branch outcome
//   (alu_zero_i ^ negzero).
//   clk_i, rst_i        clock, asynchronous active-high reset
//   bus (slave)         request/response bundle, see alu_arbiter_if
//   alu_op_o/a_o/b_o    out  drive to the shared ALU (held outside EXEC)
//   alu_result_i        in   ALU result
//   alu_zero_i          in   ALU zero flag
//   Macro ALU_ARB_ILLEGAL_OP_EN: op 4'b1111 is not sent to the ALU and is
//   answered with result 0, taken 0, rsp_err_o 1.
//
// state | meaning
// IDLE  | offering grant to one valid requester, waiting for handshake
// EXEC  | captured operands on the ALU, result registered at end of cycle
// RESP  | response presented, held until rsp_ready_i
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_arbiter_if.slave      bus,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant;
  logic [1:0]        req_ready;
  logic              accept;
  logic              sel;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] a_sel, b_sel;

  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              negzero_q;
  logic              id_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_taken_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic              illegal_q;
  logic              rsp_err_q;
`endif

  rr_arb2 u_rr_arb2 (
    .valid_i      (bus.req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign sel    = grant[1];
  assign op_sel = sel ? bus.req_op_i[2*OP_W-1:OP_W]   : bus.req_op_i[OP_W-1:0];
  assign a_sel  = sel ? bus.req_a_i[2*DATA_W-1:DATA_W] : bus.req_a_i[DATA_W-1:0];
  assign b_sel  = sel ? bus.req_b_i[2*DATA_W-1:DATA_W] : bus.req_b_i[DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) begin
          accept       = 1'b1;
          last_grant_d = sel;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is combinational from valid, so it is masked while reset is held.
  assign bus.req_ready_o = rst_i ? 2'b00 : req_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      alu_op_q     <= '1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      negzero_q    <= 1'b0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_taken_q  <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      illegal_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (accept) begin
        id_q      <= sel;
        negzero_q <= sel ? bus.req_negzero_i[1] : bus.req_negzero_i[0];
`ifdef ALU_ARB_ILLEGAL_OP_EN
        illegal_q <= (op_sel == OP_W'(OP_INVALID));
        // An illegal op leaves the ALU inputs untouched.
        if (op_sel != OP_W'(OP_INVALID)) begin
          alu_op_q <= op_sel;
          alu_a_q  <= a_sel;
          alu_b_q  <= b_sel;
        end
`else
        alu_op_q <= op_sel;
        alu_a_q  <= a_sel;
        alu_b_q  <= b_sel;
`endif
      end
      if (state_q == ST_EXEC) begin
        rsp_id_q <= id_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (illegal_q) begin
          rsp_result_q <= '0;
          rsp_taken_q  <= 1'b0;
          rsp_err_q    <= 1'b1;
        end else begin
          rsp_result_q <= alu_result_i;
          rsp_taken_q  <= alu_zero_i ^ negzero_q;
          rsp_err_q    <= 1'b0;
        end
`else
        rsp_result_q <= alu_result_i;
        rsp_taken_q  <= alu_zero_i ^ negzero_q;
`endif
      end
    end
  end

  assign alu_op_o         = alu_op_q;
  assign alu_a_o          = alu_a_q;
  assign alu_b_o          = alu_b_q;
  assign bus.rsp_valid_o  = (state_q == ST_RESP);
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_taken_o  = rsp_taken_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign bus.rsp_err_o    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Expected responses are queued by the
//   stimulus process; a monitor pops and compares on each response handshake.
//   A small behavioural ALU sits on the alu_* ports.
//   Honours ALU_ARB_ILLEGAL_OP_EN for the illegal-op case.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        taken;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_res),
    .alu_zero_i   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; unknown ops produce a recognisable marker.
  always_comb begin
    alu_res = 32'hDEAD_BEEF;
    case (alu_op)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a & alu_b;
      4'b0010: alu_res = alu_a | alu_b;
      4'b0011: alu_res = alu_a ^ alu_b;
      4'b0100: alu_res = alu_a - alu_b;
      4'b0101: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0110: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b1000: alu_res = alu_a << alu_b[4:0];
      4'b1001: alu_res = alu_a >> alu_b[4:0];
      4'b1010: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", bus.rsp_id_o, e.id);
        chk("rsp_result", bus.rsp_result_o, e.res);
        chk("rsp_taken", bus.rsp_taken_o, e.taken);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("rsp_err", bus.rsp_err_o, e.err);
`endif
      end
    end
  end

  function automatic exp_t mk(input logic id, input logic [31:0] res, input logic taken,
                              input logic err);
    exp_t e;
    e.id = id; e.res = res; e.taken = taken; e.err = err;
    return e;
  endfunction

  task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic nz);
    bus.req_op_i[k*4 +: 4]   = op;
    bus.req_a_i[k*32 +: 32]  = a;
    bus.req_b_i[k*32 +: 32]  = b;
    bus.req_negzero_i[k]     = nz;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic wait_accept(input int k);
    int cyc = 0;
    bit ok = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.req_valid_i[k] && bus.req_ready_o[k]) ok = 1;
    end
    if (!ok) fail_now("accept_wait");
    @(posedge clk); #1;
    bus.req_valid_i[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic nz);
    set_req(k, op, a, b, nz);
    bus.req_valid_i[k] = 1'b1;
    wait_accept(k);
  endtask

  // Both requesters held valid for n accepts; grants must alternate from req0.
  task automatic run_both(input int n);
    int got = 0;
    int cyc = 0;
    logic [1:0] eg = 2'b01;
    bus.req_valid_i = 2'b11;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (|bus.req_ready_o) begin
        chk("rr_grant", bus.req_ready_o, eg);
        eg = ~eg;
        got++;
      end
    end
    if (got < n) fail_now("run_both");
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid_o) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready_i   = 1'b1;
    bus.req_valid_i   = 2'b11;
    bus.req_op_i      = '0;
    bus.req_a_i       = '0;
    bus.req_b_i       = '0;
    bus.req_negzero_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready_o, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    chk("rst_rsp_id", bus.rsp_id_o, 1'b0);
    chk("rst_rsp_result", bus.rsp_result_o, 32'd0);
    chk("rst_rsp_taken", bus.rsp_taken_o, 1'b0);
    chk("rst_alu_op", alu_op, 4'b1111);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("rst_rsp_err", bus.rsp_err_o, 1'b0);
`endif
    bus.req_valid_i = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single request latency
    exp_q.push_back(mk(1'b0, 32'd12, 1'b0, 1'b0));
    set_req(0, 4'b0000, 32'd5, 32'd7, 1'b0);
    bus.req_valid_i[0] = 1'b1;
    @(negedge clk);
    chk("t1_ready", bus.req_ready_o, 2'b01);
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    chk("t1_exec_valid", bus.rsp_valid_o, 1'b0);
    chk("t1_alu_op", alu_op, 4'b0000);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    chk("t1_exec_ready", bus.req_ready_o, 2'b00);
    @(negedge clk);
    chk("t1_resp_valid", bus.rsp_valid_o, 1'b1);
    drain();

    // 2: contention after reset, alternating grants
    pulse_reset();
    set_req(0, 4'b0100, 32'd9, 32'd9, 1'b0);
    set_req(1, 4'b0101, 32'd3, 32'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, 32'd1, 1'b1, 1'b0));
    end
    run_both(8);
    drain();

    // 3: response backpressure
    bus.rsp_ready_i = 1'b0;
    exp_q.push_back(mk(1'b1, 32'h0000_000F, 1'b0, 1'b0));
    send(1, 4'b0011, 32'h0000_00F0, 32'h0000_00FF, 1'b0);
    exp_q.push_back(mk(1'b0, 32'd8, 1'b0, 1'b0));
    set_req(0, 4'b0001, 32'hC, 32'hA, 1'b0);
    bus.req_valid_i[0] = 1'b1;
    begin
      int cyc = 0;
      while (!bus.rsp_valid_o && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      if (!bus.rsp_valid_o) fail_now("t3_rsp_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.rsp_valid_o, 1'b1);
      chk("t3_hold_id", bus.rsp_id_o, 1'b1);
      chk("t3_hold_result", bus.rsp_result_o, 32'h0000_000F);
      chk("t3_hold_taken", bus.rsp_taken_o, 1'b0);
      chk("t3_hold_ready", bus.req_ready_o, 2'b00);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    wait_accept(0);
    drain();

    // 4: reset during EXEC drops the transaction; req0 wins next
    send(1, 4'b0000, 32'd1, 32'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", bus.rsp_valid_o, 1'b0);
    chk("t4_rst_alu_op", alu_op, 4'b1111);
    chk("t4_rst_alu_a", alu_a, 32'd0);
    chk("t4_rst_alu_b", alu_b, 32'd0);
    chk("t4_rst_result", bus.rsp_result_o, 32'd0);
    chk("t4_rst_ready", bus.req_ready_o, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 4'b0010, 32'h30, 32'h03, 1'b0);
    set_req(1, 4'b1001, 32'h80, 32'd3, 1'b0);
    exp_q.push_back(mk(1'b0, 32'h33, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0));
    run_both(2);
    drain();

    // 5: BGE-style compare
    exp_q.push_back(mk(1'b0, 32'd1, 1'b0, 1'b0));
    send(0, 4'b0101, 32'hFFFF_FFFF, 32'd0, 1'b0);
    exp_q.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0));
    send(0, 4'b0101, 32'd4, 32'hFFFF_FFFE, 1'b0);
    drain();

    // 6: op 4'b1111
`ifdef ALU_ARB_ILLEGAL_OP_EN
    exp_q.push_back(mk(1'b1, 32'd0, 1'b0, 1'b1));
`else
    exp_q.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0));
`endif
    send(1, 4'b1111, 32'd3, 32'd4, 1'b0);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
